// File: rtl/alu_logic_if.sv
// Operand/function/result bundle between the MIPS ALU top level and its logic unit.
// The master drives operands and function code; the slave returns the registered result.
interface alu_logic_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [5:0]       ALUFun;
   logic [WIDTH-1:0] S;

   modport master (
      output A,
      output B,
      output ALUFun,
      input  S
   );

   modport slave (
      input  A,
      input  B,
      input  ALUFun,
      output S
   );
endinterface

// File: rtl/alu_logic.sv
// Bitwise logic unit of the MIPS ALU: ALUFun[3:0] is a per-bit truth table over (A,B),
// and the registered result is forced to zero unless this unit's group (01) is selected.
module alu_logic #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   alu_logic_if.slave  bus
);

   localparam logic [1:0] LOGIC_GROUP = 2'b01;

   logic             group_sel;
   logic [3:0]       truth_table;
   logic [WIDTH-1:0] logic_result;
   logic [WIDTH-1:0] next_s;

   assign group_sel   = (bus.ALUFun[5:4] == LOGIC_GROUP);
   assign truth_table = bus.ALUFun[3:0];

   // Each truth-table bit enables one of the four (A,B) minterms across the whole word.
   always_comb begin
      logic_result = ( bus.A &  bus.B & {WIDTH{truth_table[3]}})
                   | (~bus.A &  bus.B & {WIDTH{truth_table[2]}})
                   | ( bus.A & ~bus.B & {WIDTH{truth_table[1]}})
                   | (~bus.A & ~bus.B & {WIDTH{truth_table[0]}});
   end

   // Zero when another group is selected so the top level can OR all unit outputs.
   always_comb begin
      next_s = '0;
      if (group_sel) begin
         next_s = logic_result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.S <= '0;
      end else begin
         bus.S <= next_s;
      end
   end

endmodule

// File: tb/tb_alu_logic.sv
// Self-checking bench for alu_logic: a lookup-table reference model checked every cycle,
// plus hand-computed expectations for the directed vectors.
module tb_alu_logic;

   localparam int WIDTH = 32;

   logic clk;
   logic reset;

   alu_logic_if #(.WIDTH(WIDTH)) bus ();

   alu_logic #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] exp_s;
   logic             exp_valid = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: each result bit looks up the truth table at index {B[i],A[i]}.
   function automatic logic [WIDTH-1:0] refLogic(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [5:0]       fun);
      logic [WIDTH-1:0] r;
      logic [3:0]       tt;
      logic [1:0]       idx;
      r  = '0;
      tt = fun[3:0];
      if (fun[5:4] != 2'b01) return r;
      for (int i = 0; i < WIDTH; i++) begin
         idx  = {b[i], a[i]};
         r[i] = tt[idx];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      exp_s     <= reset ? '0 : refLogic(bus.A, bus.B, bus.ALUFun);
      exp_valid <= 1'b1;
   end

   // Compare the DUT against the model on every cycle, away from the active edge.
   always @(negedge clk) begin
      if (exp_valid) begin
         checks++;
         if (bus.S !== exp_s) begin
            errors++;
            $display("[TB] FAIL model_cmp: S=%h expected %h (A=%h B=%h ALUFun=%b reset=%b)",
                     bus.S, exp_s, bus.A, bus.B, bus.ALUFun, reset);
         end
      end
   end

   task automatic applyStimulus(input logic rst, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [5:0] fun);
      reset      = rst;
      bus.A      = a;
      bus.B      = b;
      bus.ALUFun = fun;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] expected);
      checks++;
      if (bus.S !== expected) begin
         errors++;
         $display("[TB] FAIL %s: S=%h expected %h", name, bus.S, expected);
      end
   endtask

   localparam logic [WIDTH-1:0] VA = 32'h8000_0005;
   localparam logic [WIDTH-1:0] VB = 32'h8000_0003;
   localparam logic [WIDTH-1:0] SA = 32'hFF00_FF00;
   localparam logic [WIDTH-1:0] SB = 32'hF0F0_F0F0;

   initial begin
      logic [1:0] grp;
      logic [3:0] tt;

      $display("[TB] start");
      applyStimulus(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 6'b011111);
      checkOutput("reset_state", 32'h0);

      applyStimulus(1'b1, VA, VB, 6'b011110);
      checkOutput("reset_hold_or", 32'h0);
      applyStimulus(1'b0, VA, VB, 6'b011110);
      checkOutput("or_after_reset", 32'h8000_0007);

      // Back-to-back operations, one per edge.
      applyStimulus(1'b0, VA, VB, 6'b011000);
      checkOutput("and", 32'h8000_0001);
      applyStimulus(1'b0, VA, VB, 6'b010110);
      checkOutput("xor", 32'h0000_0006);
      applyStimulus(1'b0, VA, VB, 6'b010001);
      checkOutput("nor", 32'h7FFF_FFF8);
      applyStimulus(1'b0, VA, VB, 6'b011010);
      checkOutput("pass_a", 32'h8000_0005);
      applyStimulus(1'b0, VA, VB, 6'b011110);
      checkOutput("or", 32'h8000_0007);

      applyStimulus(1'b0, VA, VB, 6'b000000);
      checkOutput("group_00", 32'h0);
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 6'b111111);
      checkOutput("group_11", 32'h0);
      applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'b101000);
      checkOutput("group_10", 32'h0);

      applyStimulus(1'b0, SA, SB, 6'b011000);
      applyStimulus(1'b1, SA, SB, 6'b011111);
      checkOutput("reset_priority", 32'h0);

      // Sweep every truth-table code; the model checks each one.
      for (int code = 0; code < 16; code++) begin
         tt = 4'(code);
         applyStimulus(1'b0, SA, SB, {2'b01, tt});
         if (code == 0)  checkOutput("sweep_0000", 32'h0);
         if (code == 3)  checkOutput("sweep_0011", 32'h0F0F_0F0F);
         if (code == 12) checkOutput("sweep_1100", SB);
         if (code == 15) checkOutput("sweep_1111", 32'hFFFF_FFFF);
      end

      for (int n = 0; n < 400; n++) begin
         grp = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
         tt  = 4'($urandom_range(0, 15));
         applyStimulus(($urandom_range(0, 19) == 0), $urandom, $urandom, {grp, tt});
      end

      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
